// File: rtl/ones_enumerator_pkg.sv
// ============================================================================
// Module      : ones_enumerator_pkg
// Description : Shared types for the set-bit index enumerator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ones_enumerator_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/ones_enumerator_lsb_index.sv
// ============================================================================
// Module      : lsb_index
// Description : Combinational lowest-set-bit priority encoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsb_index #(
    parameter int WIDTH    = 32,
    parameter int IDXWIDTH = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]    vec,
    output logic [IDXWIDTH-1:0] idx,
    output logic                any
);

    // Scan from the top down so the lowest set bit is the last writer.
    always_comb begin
        idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDXWIDTH'(i);
            end
        end
    end

    assign any = |vec;

endmodule

`default_nettype wire

// File: rtl/ones_enumerator.sv
// ============================================================================
// Module      : ones_enumerator
// Description : Streams the index of every set bit of an accepted vector in
//               ascending order; optional ones count via
//               ONES_ENUMERATOR_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ones_enumerator
    import ones_enumerator_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int IDXWIDTH = $clog2(WIDTH),
    parameter int CNTWIDTH = $clog2(WIDTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    in_vec,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [IDXWIDTH-1:0] out_idx,
    output logic                out_last,
    output logic                out_empty
`ifdef ONES_ENUMERATOR_COUNT_EN
    ,
    output logic [CNTWIDTH-1:0] out_count
`endif
);

    if (WIDTH < 2 || IDXWIDTH < 1 || CNTWIDTH < 1) begin : g_width_check
        $error("ones_enumerator: WIDTH must be 2 or more");
    end

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   pending_q, pending_d;
    logic               empty_q, empty_d;

    logic               w_accept;
    logic               w_xfer;
    logic               w_last;
    logic               w_any;
    logic [IDXWIDTH-1:0] w_lsb_idx;
    logic [WIDTH-1:0]   w_pending_clr;

    lsb_index #(
        .WIDTH    (WIDTH),
        .IDXWIDTH (IDXWIDTH)
    ) u_lsb_index (
        .vec (pending_q),
        .idx (w_lsb_idx),
        .any (w_any)
    );

    assign in_ready      = (state_q == IDLE) && !rst;
    assign out_valid     = (state_q == EMIT) && !rst;
    assign w_accept      = in_valid && in_ready;
    assign w_xfer        = out_valid && out_ready;
    assign w_pending_clr = pending_q & (pending_q - WIDTH'(1));
    assign w_last        = empty_q || (w_pending_clr == '0);

    // Outputs read as zero whenever no beat is on offer.
    assign out_idx   = (out_valid && w_any) ? w_lsb_idx : '0;
    assign out_last  = out_valid && w_last;
    assign out_empty = out_valid && empty_q;

`ifdef ONES_ENUMERATOR_COUNT_EN
    logic [CNTWIDTH-1:0] cnt_q, cnt_d;
    logic [CNTWIDTH-1:0] beats_q;

    assign out_count = out_valid ? cnt_q : '0;
`endif

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        empty_d   = empty_q;
`ifdef ONES_ENUMERATOR_COUNT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    pending_d = in_vec;
                    empty_d   = (in_vec == '0);
                    state_d   = EMIT;
`ifdef ONES_ENUMERATOR_COUNT_EN
                    cnt_d     = CNTWIDTH'($countones(in_vec));
`endif
                end
            end
            EMIT: begin
                if (w_xfer) begin
                    pending_d = w_pending_clr;
                    if (w_last) begin
                        state_d = IDLE;
                        empty_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            empty_q   <= 1'b0;
`ifdef ONES_ENUMERATOR_COUNT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            empty_q   <= empty_d;
`ifdef ONES_ENUMERATOR_COUNT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

`ifdef ONES_ENUMERATOR_COUNT_EN
    // A vector must close after exactly popcount beats, or one beat if zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            beats_q <= '0;
        end else if (w_xfer) begin
            if (w_last) begin
                assert (beats_q + 1'b1 == ((cnt_q == '0) ? CNTWIDTH'(1) : cnt_q));
                beats_q <= '0;
            end else begin
                beats_q <= beats_q + 1'b1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_ones_enumerator.sv
// ============================================================================
// Module      : tb_ones_enumerator
// Description : Directed vector bench for ones_enumerator (WIDTH 8 and 32).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ones_enumerator;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid8, in_ready8, out_valid8, out_ready8, out_last8, out_empty8;
    logic [7:0]  in_vec8;
    logic [2:0]  out_idx8;
    logic        in_valid32, in_ready32, out_valid32, out_ready32, out_last32, out_empty32;
    logic [31:0] in_vec32;
    logic [4:0]  out_idx32;
`ifdef ONES_ENUMERATOR_COUNT_EN
    logic [3:0]  out_count8;
    logic [5:0]  out_count32;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ones_enumerator #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .in_vec    (in_vec8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .out_idx   (out_idx8),
        .out_last  (out_last8),
        .out_empty (out_empty8)
`ifdef ONES_ENUMERATOR_COUNT_EN
        ,
        .out_count (out_count8)
`endif
    );

    ones_enumerator #(.WIDTH(32)) dut32 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid32),
        .in_ready  (in_ready32),
        .in_vec    (in_vec32),
        .out_valid (out_valid32),
        .out_ready (out_ready32),
        .out_idx   (out_idx32),
        .out_last  (out_last32),
        .out_empty (out_empty32)
`ifdef ONES_ENUMERATOR_COUNT_EN
        ,
        .out_count (out_count32)
`endif
    );

    typedef struct {
        logic [7:0]  vec;
        int          n;
        logic [31:0] idxs;   // nibble k holds the k-th expected index
        bit          empty;
        int          cnt;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic beat8(input int idx, input bit last, input bit empty, input int cnt);
        chk("valid8", 32'(out_valid8), 32'd1);
        chk("idx8", 32'(out_idx8), 32'(idx));
        chk("last8", 32'(out_last8), 32'(last));
        chk("empty8", 32'(out_empty8), 32'(empty));
`ifdef ONES_ENUMERATOR_COUNT_EN
        chk("count8", 32'(out_count8), 32'(cnt));
`else
        if (cnt < 0) chk("count8_neg", 32'(cnt), 32'd0);
`endif
        @(negedge clk);
    endtask

    task automatic idle8();
        chk("idle_in_ready8", 32'(in_ready8), 32'd1);
        chk("idle_valid8", 32'(out_valid8), 32'd0);
        chk("idle_idx8", 32'(out_idx8), 32'd0);
`ifdef ONES_ENUMERATOR_COUNT_EN
        chk("idle_count8", 32'(out_count8), 32'd0);
`endif
    endtask

    task automatic send8(input logic [7:0] v);
        in_valid8 = 1'b1;
        in_vec8   = v;
        chk("accept_ready8", 32'(in_ready8), 32'd1);
        @(negedge clk);
        in_valid8 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{vec: 8'hA4, n: 3, idxs: 32'h0000_0752, empty: 1'b0, cnt: 3};
        tbl[1] = '{vec: 8'h00, n: 1, idxs: 32'h0000_0000, empty: 1'b1, cnt: 0};
        tbl[2] = '{vec: 8'hFF, n: 8, idxs: 32'h7654_3210, empty: 1'b0, cnt: 8};
        tbl[3] = '{vec: 8'h80, n: 1, idxs: 32'h0000_0007, empty: 1'b0, cnt: 1};
        tbl[4] = '{vec: 8'h01, n: 1, idxs: 32'h0000_0000, empty: 1'b0, cnt: 1};
        tbl[5] = '{vec: 8'h5A, n: 4, idxs: 32'h0000_6431, empty: 1'b0, cnt: 4};

        rst = 1'b1;
        in_valid8 = 1'b0; in_vec8 = '0; out_ready8 = 1'b1;
        in_valid32 = 1'b0; in_vec32 = '0; out_ready32 = 1'b1;

        @(negedge clk);
        chk("rst_in_ready8", 32'(in_ready8), 32'd0);
        chk("rst_valid8", 32'(out_valid8), 32'd0);
        chk("rst_last8", 32'(out_last8), 32'd0);
        chk("rst_empty8", 32'(out_empty8), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        idle8();
        chk("post_rst_last8", 32'(out_last8), 32'd0);
        chk("post_rst_empty8", 32'(out_empty8), 32'd0);

        // Table-driven vectors with full-rate consumer.
        for (int i = 0; i < 6; i++) begin
            send8(tbl[i].vec);
            for (int k = 0; k < tbl[i].n; k++) begin
                beat8(int'((tbl[i].idxs >> (4 * k)) & 32'hF), k == tbl[i].n - 1,
                      tbl[i].empty, tbl[i].cnt);
            end
            idle8();
        end

        // Backpressure on first beat, with new input offered during EMIT.
        send8(8'h12);
        out_ready8 = 1'b0;
        in_valid8  = 1'b1;
        in_vec8    = 8'hFF;
        for (int s = 0; s < 3; s++) begin
            chk("bp_in_ready8", 32'(in_ready8), 32'd0);
            chk("bp_idx8", 32'(out_idx8), 32'd1);
            chk("bp_last8", 32'(out_last8), 32'd0);
            chk("bp_valid8", 32'(out_valid8), 32'd1);
            @(negedge clk);
        end
        out_ready8 = 1'b1;
        beat8(1, 1'b0, 1'b0, 2);
        in_valid8 = 1'b0;
        beat8(4, 1'b1, 1'b0, 2);
        idle8();
        @(negedge clk);
        chk("bp_no_accept_valid8", 32'(out_valid8), 32'd0);

        // Reset in the middle of a vector abandons remaining indices.
        send8(8'hC1);
        beat8(0, 1'b0, 1'b0, 3);
        chk("mid_idx8", 32'(out_idx8), 32'd6);
        rst = 1'b1;
        #1;
        chk("mrst_valid8", 32'(out_valid8), 32'd0);
        chk("mrst_in_ready8", 32'(in_ready8), 32'd0);
        chk("mrst_idx8", 32'(out_idx8), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        idle8();
        send8(8'h80);
        beat8(7, 1'b1, 1'b0, 1);
        idle8();

        // 32-bit instance: extreme bits.
        in_valid32 = 1'b1;
        in_vec32   = 32'h8000_0001;
        chk("accept_ready32", 32'(in_ready32), 32'd1);
        @(negedge clk);
        in_valid32 = 1'b0;
        chk("w32_valid0", 32'(out_valid32), 32'd1);
        chk("w32_idx0", 32'(out_idx32), 32'd0);
        chk("w32_last0", 32'(out_last32), 32'd0);
`ifdef ONES_ENUMERATOR_COUNT_EN
        chk("w32_count", 32'(out_count32), 32'd2);
`endif
        @(negedge clk);
        chk("w32_valid1", 32'(out_valid32), 32'd1);
        chk("w32_idx1", 32'(out_idx32), 32'd31);
        chk("w32_last1", 32'(out_last32), 32'd1);
        chk("w32_empty1", 32'(out_empty32), 32'd0);
        @(negedge clk);
        chk("w32_idle_valid", 32'(out_valid32), 32'd0);
        chk("w32_idle_ready", 32'(in_ready32), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
